uart_transmitter: RTL and testbench

Serializes one parallel byte per transaction onto a single-wire UART line: start bit, 8 data bits MSB first, optional even-parity bit, one stop bit. Sits on the transmit side of the simple UART link. Bytes are accepted from the host logic through a valid/ready handshake, and the block drives the idle-high serial output.

---
 rtl/uart_transmitter.sv | 136 +++++++++++++
 tb/tb_uart_transmitter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits MSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit after the data bits.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       tx_ready,
  output logic       bit_out,
  output logic       busy,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] baud_cnt;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  assign bit_end = (baud_cnt == CNT_LAST);

  // Outputs are registered alongside the state so each one changes on the same edge as the state it reflects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= 8'h00;
      bit_idx    <= 3'd0;
      baud_cnt   <= '0;
      bit_out    <= 1'b1;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= 3'd0;
          if (data_valid && tx_ready) begin
            shift_reg  <= data_in;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^data_in;
`endif
            state      <= START;
            bit_out    <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= DATA;
            bit_out  <= shift_reg[7];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // The next line value is the bit that becomes MSB after this shift.
        DATA: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= {shift_reg[6:0], 1'b0};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              bit_out <= parity_bit;
`else
              state   <= STOP;
              bit_out <= 1'b1;
`endif
            end else begin
              bit_out <= shift_reg[6];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= STOP;
            bit_out  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
            bit_out  <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_out  <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter: directed and random frames checked cycle by cycle
// against a slot-based frame model (honours UART_TX_PARITY_EN).
module tb_uart_transmitter;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int F = NSLOT * CPB;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       tx_ready;
  logic       bit_out;
  logic       busy;
  logic       tx_done;

  int vectors     = 0;
  int miscompares = 0;
  int frame_no    = 0;

  logic [7:0] rnd;
  logic       rhold;
  int         rpoke;

  uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .tx_ready  (tx_ready),
    .bit_out   (bit_out),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line level during frame slot s: start, data MSB first, optional parity, stop.
  function automatic logic model_slot(input logic [7:0] d, input int s);
    logic [7:0] t;
    if (s == 0) return 1'b0;
    if (s == NSLOT - 1) return 1'b1;
    if (s <= 8) begin
      t = d >> (8 - s);
      return t[0];
    end
    return ^d;
  endfunction

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag, input logic done_exp);
    checkOutput({tag, "_tx_done"}, tx_done, done_exp);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_tx_ready"}, tx_ready, 1'b1);
    checkOutput({tag, "_bit_out"}, bit_out, 1'b1);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkIdle($sformatf("idle_f%0d_c%0d", frame_no, i), 1'b0);
    end
  endtask

  // Checks every cycle of a frame that was accepted on the preceding edge, then the tx_done cycle.
  task automatic expectFrame(input logic [7:0] d, input int poke_j, input logic [7:0] poke_d,
                             input logic hold);
    string tag;
    frame_no++;
    for (int j = 0; j < F; j++) begin
      @(negedge clk);
      tag = $sformatf("f%0d_%02h_c%0d", frame_no, d, j);
      checkOutput({tag, "_bit_out"}, bit_out, model_slot(d, j / CPB));
      checkOutput({tag, "_busy"}, busy, 1'b1);
      checkOutput({tag, "_tx_ready"}, tx_ready, 1'b0);
      checkOutput({tag, "_tx_done"}, tx_done, 1'b0);
      if (j == poke_j) begin
        data_in    = poke_d;
        data_valid = 1'b1;
      end
      if (j == poke_j + 1) data_valid = hold;
    end
    @(negedge clk);
    checkIdle($sformatf("f%0d_%02h_done", frame_no, d), 1'b1);
  endtask

  // Called between edges with the DUT in IDLE; the byte is accepted on the next rising edge.
  task automatic applyStimulus(input logic [7:0] d, input logic hold, input int poke_j,
                               input logic [7:0] poke_d);
    data_in    = d;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_in = ~d;
    expectFrame(d, poke_j, poke_d, hold);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkIdle($sformatf("in_reset_c%0d", i), 1'b0);
    end
    rst = 1'b0;
    idleCycles(3);

    $display("[TB] basic frames");
    applyStimulus(8'hA5, 1'b0, -1, 8'h00);
    idleCycles(2);
    applyStimulus(8'h01, 1'b0, -1, 8'h00);

    $display("[TB] back-to-back with data_valid held");
    applyStimulus(8'h00, 1'b1, -1, 8'h00);
    applyStimulus(8'hFF, 1'b0, -1, 8'h00);
    idleCycles(1);

    $display("[TB] ignored mid-frame request");
    applyStimulus(8'h81, 1'b0, 13, 8'h3C);
    idleCycles(2);

    $display("[TB] reset during data bit 3");
    data_in    = 8'hF0;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    repeat (4 * CPB + 2) @(negedge clk);
    checkOutput("rst_pre_bit_out", bit_out, model_slot(8'hF0, 4));
    checkOutput("rst_pre_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    checkIdle("rst_async", 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkIdle($sformatf("rst_hold_c%0d", i), 1'b0);
    end
    rst = 1'b0;
    idleCycles(12 * CPB);
    applyStimulus(8'h55, 1'b0, -1, 8'h00);
    idleCycles(1);

    $display("[TB] random frames");
    for (int i = 0; i < 8; i++) begin
      rnd   = 8'($urandom);
      rhold = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      rpoke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, F - 3)) : -1;
      applyStimulus(rnd, rhold, rpoke, 8'($urandom));
      if (!rhold) idleCycles(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
